fpgc4_shell: RTL and testbench
==============================

Name: fpgc4_shell

Overview:
- Reduced FPGC4 top-level shell: SPI flash boot loader, 640x480 VGA timing/pixel generator, and a parked SDRAM interface.
- After reset it waits a startup delay, then reads BOOT_WORDS 32-bit words from SPI flash (W25Q128JV) address 0 into an internal buffer using command 0x03.
- It displays the buffer bytes as colour bars on VGA.
- It holds the SDRAM (mt48lc16m16a2) in command-inhibit with a forwarded clock.

Parameters:
- BOOT_WORDS, 16, number of 32-bit words loaded from flash (1..64).
- SPI_DIV, 2, spi_clk half-period in clk cycles (>=1).
- STARTUP_CYCLES, 100, clk cycles idle after reset release before spi_cs falls.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- vga_clk  out  1  pixel clock, clk/2
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_r  out  3  red
- vga_g  out  3  green
- vga_b  out  2  blue
- vga_blk  out  1  1 = visible area, 0 = blanking
- SDRAM_CLK  out  1  ~clk
- SDRAM_CKE  out  1  clock enable
- SDRAM_CSn  out  1  chip select
- SDRAM_WEn  out  1  write enable
- SDRAM_CASn  out  1  CAS
- SDRAM_RASn  out  1  RAS
- SDRAM_A  out  13  address
- SDRAM_BA  out  2  bank
- SDRAM_DQM  out  2  byte mask
- SDRAM_DQ  inout  16  data, never driven
- spi_clk  out  1  SPI clock, mode 0
- spi_data  out  1  MOSI (flash DI)
- spi_q  in  1  MISO (flash DO)
- spi_wp  out  1  write protect, constant 1
- spi_hold  out  1  hold, constant 1
- spi_cs  out  1  chip select, active low

Behaviour:
- Single clock domain (clk). Reset is synchronous, active-high, sampled on rising clk.
- Reset values:
  - spi_cs=1, spi_clk=0, spi_data=0.
  - vga_clk=0, vga_hs=1, vga_vs=1, colours=0, vga_blk=0.
  - Boot buffer cleared to 0, boot_done=0.
- SDRAM is static in and out of reset:
  - CKE=1, CSn=RASn=CASn=WEn=1, A=0, BA=0, DQM=2'b11.
  - DQ is high-Z.
  - SDRAM_CLK = ~clk (combinational).
- Boot FSM states: WAIT, CMD, ADDR, DATA, DONE.
- WAIT:
  - Counts STARTUP_CYCLES clk cycles after reset deasserts.
  - Then asserts spi_cs=0 and spi_data = first bit; goes to CMD.
- SPI bit timing:
  - Each bit lasts 2*SPI_DIV clk cycles: spi_clk low for SPI_DIV cycles, then high for SPI_DIV.
  - MOSI changes only while spi_clk is low (on the falling-edge cycle).
  - spi_q is sampled on the clk edge where spi_clk rises.
- CMD: shifts 8 bits of 0x03, MSB first.
- ADDR: shifts 24 zero bits.
- DATA:
  - Shifts in 32*BOOT_WORDS bits, MSB first.
  - Word k = flash bytes 4k..4k+3, big-endian (byte 4k lands in bits 31:24).
- After the final rising-edge sample, spi_clk returns to 0. spi_cs=1 on the next clk; boot_done=1; state DONE.
- DONE: spi_cs stays 1 and spi_clk stays 0 until reset.
- Total boot time after reset release: STARTUP_CYCLES + (32+32*BOOT_WORDS)*2*SPI_DIV cycles, ±2.
- Reset mid-boot: spi_cs=1 and spi_clk=0 on the next edge; buffer cleared; sequence restarts from WAIT after release.
- VGA timing:
  - vga_clk toggles every clk. Counters advance on clk cycles where vga_clk goes 0->1.
  - h counter 0..799: active 0..639, front porch 640..655, sync 656..751, back porch 752..799. Wraps 799->0 and increments v.
  - v counter 0..524: active 0..479, front porch 480..489, sync 490..491, back porch 492..524. Wraps 524->0.
  - vga_hs=0 exactly for h 656..751; vga_vs=0 exactly for v 490..491.
  - vga_blk=1 iff h<640 and v<480.
  - All VGA outputs are registered, one pixel of latency from the counters.
- Pixel colour:
  - Blanked or boot_done=0: rgb = 0.
  - Otherwise byte index i = (h>>5) mod (4*BOOT_WORDS). Byte i = byte (i mod 4) of word i/4, with byte 0 = bits 31:24.
  - r = byte[7:5], g = byte[4:2], b = byte[1:0].

Test Plan:
- Reset held 5 cycles, then released; check during reset and for STARTUP_CYCLES-1 cycles after release -> spi_cs=1, spi_clk=0. Check SDRAM pins static: CSn=1, DQM=11, DQ=Z; SDRAM_CLK=~clk.
- Flash preloaded with 0xDE 0xAD 0xBE 0xEF at address 0 -> MOSI carries 0x03 then 0x000000. Word0=0xDEADBEEF. spi_cs rises at 100+544*4 = 2276 ±2 cycles.
- After boot, pixels h=0..31 on line v=0 -> rgb = 3'b110, 3'b111, 2'b10 (byte 0xDE). Pixels h=32..63 -> byte 0xAD.
- Count one line: hs low for 96 pixel clocks, period 800 pixel clocks (1600 clk cycles). vga_blk high for 640 pixel clocks; rgb=0 while vga_blk=0.
- Count frame (or force counters): vs low for 2 lines, every 525 lines. Before boot_done, every pixel is 0 even while vga_blk=1.
- Assert reset at cycle 600 (mid-DATA) for 3 cycles -> spi_cs=1 within 1 cycle. After release, a new 0x03 command starts 100 cycles later; final buffer is still correct.

Source files
------------

// File: rtl/fpgc4_shell.sv
// FPGC4 reduced shell: boots BOOT_WORDS words from SPI flash, shows them as VGA colour bars,
// and parks the SDRAM in command-inhibit.
module fpgc4_shell #(
  parameter int BOOT_WORDS     = 16,
  parameter int SPI_DIV        = 2,
  parameter int STARTUP_CYCLES = 100
) (
  input  logic        clk,
  input  logic        reset,
  output logic        vga_clk,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [2:0]  vga_r,
  output logic [2:0]  vga_g,
  output logic [1:0]  vga_b,
  output logic        vga_blk,
  output logic        SDRAM_CLK,
  output logic        SDRAM_CKE,
  output logic        SDRAM_CSn,
  output logic        SDRAM_WEn,
  output logic        SDRAM_CASn,
  output logic        SDRAM_RASn,
  output logic [12:0] SDRAM_A,
  output logic [1:0]  SDRAM_BA,
  output logic [1:0]  SDRAM_DQM,
  inout  wire  [15:0] SDRAM_DQ,
  output logic        spi_clk,
  output logic        spi_data,
  input  logic        spi_q,
  output logic        spi_wp,
  output logic        spi_hold,
  output logic        spi_cs
);
  localparam int TOTAL_BITS = 32 + 32*BOOT_WORDS;
  localparam int BUF_W      = 32*BOOT_WORDS;
  localparam int NBYTES     = 4*BOOT_WORDS;
  localparam int BIT_W      = $clog2(TOTAL_BITS);
  localparam int IDX_W      = $clog2(BUF_W);
  localparam int DIV_W      = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam int WAIT_W     = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(TOTAL_BITS-1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SPI_DIV-1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARTUP_CYCLES-1);
  localparam logic [7:0]        CMD_RD    = 8'h03;

  typedef enum logic [2:0] {S_WAIT, S_CMD, S_ADDR, S_DATA, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d, bit_nx;
  logic               sclk_q, sclk_d, cs_q, cs_d, mosi_q, mosi_d, done_q, done_d;
  logic [BUF_W-1:0]   buf_q, buf_d;

  // Bit index n covers command (0..7), address (8..31), then data.
  function automatic logic mosi_of(input logic [BIT_W-1:0] n);
    return (n < BIT_W'(8)) && CMD_RD[~n[2:0]];
  endfunction

  function automatic state_e phase_of(input logic [BIT_W-1:0] n);
    if (n < BIT_W'(8))  return S_CMD;
    if (n < BIT_W'(32)) return S_ADDR;
    return S_DATA;
  endfunction

  assign bit_nx = bit_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      wait_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      buf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    buf_d   = buf_q;
    done_d  = done_q;
    unique case (state_q)
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_CMD;
          cs_d    = 1'b0;
          mosi_d  = mosi_of('0);
          div_d   = '0;
          bit_d   = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_CMD, S_ADDR, S_DATA: begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        if (div_q == DIV_LAST) begin
          if (!sclk_q) begin
            // Rising spi_clk: flash data is sampled here, MSB first, so byte 0 ends up on top.
            sclk_d = 1'b1;
            if (state_q == S_DATA) buf_d = {buf_q[BUF_W-2:0], spi_q};
          end else if (bit_q == LAST_BIT) begin
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            cs_d    = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            sclk_d  = 1'b0;
            bit_d   = bit_nx;
            mosi_d  = mosi_of(bit_nx);
            state_d = phase_of(bit_nx);
          end
        end
      end
      default: ;
    endcase
  end

  assign spi_clk  = sclk_q;
  assign spi_cs   = cs_q;
  assign spi_data = mosi_q;
  assign spi_wp   = 1'b1;
  assign spi_hold = 1'b1;

  logic             vclk_q, hs_q, vs_q, blk_q, vis;
  logic [9:0]       h_q, h_d, v_q, v_d;
  logic [7:0]       rgb_q, pix_byte;
  logic [IDX_W-1:0] byte_lsb;

  always_comb begin
    h_d = (h_q == 10'd799) ? 10'd0 : h_q + 10'd1;
    v_d = v_q;
    if (h_q == 10'd799) v_d = (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
  end

  assign vis      = (h_q < 10'd640) && (v_q < 10'd480);
  assign byte_lsb = IDX_W'((NBYTES - 1 - (int'(h_q[9:5]) % NBYTES)) * 8);
  assign pix_byte = buf_q[byte_lsb +: 8];

  // Outputs are registered from the pre-advance counters: one pixel of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      vclk_q <= 1'b0;
      h_q    <= '0;
      v_q    <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      blk_q  <= 1'b0;
      rgb_q  <= '0;
    end else begin
      vclk_q <= ~vclk_q;
      if (!vclk_q) begin
        h_q   <= h_d;
        v_q   <= v_d;
        hs_q  <= !((h_q >= 10'd656) && (h_q <= 10'd751));
        vs_q  <= !((v_q >= 10'd490) && (v_q <= 10'd491));
        blk_q <= vis;
        rgb_q <= (vis && done_q) ? pix_byte : 8'h00;
      end
    end
  end

  assign vga_clk = vclk_q;
  assign vga_hs  = hs_q;
  assign vga_vs  = vs_q;
  assign vga_blk = blk_q;
  assign vga_r   = rgb_q[7:5];
  assign vga_g   = rgb_q[4:2];
  assign vga_b   = rgb_q[1:0];

  assign SDRAM_CLK  = ~clk;
  assign SDRAM_CKE  = 1'b1;
  assign SDRAM_CSn  = 1'b1;
  assign SDRAM_RASn = 1'b1;
  assign SDRAM_CASn = 1'b1;
  assign SDRAM_WEn  = 1'b1;
  assign SDRAM_A    = '0;
  assign SDRAM_BA   = '0;
  assign SDRAM_DQM  = 2'b11;
  assign SDRAM_DQ   = 16'hzzzz;
endmodule

// File: tb/tb_fpgc4_shell.sv
// Bench for fpgc4_shell: SPI flash model, closed-form timing/pixel model checked every cycle.
module tb_fpgc4_shell;
  localparam int BW    = 16;
  localparam int DIV   = 2;
  localparam int ST    = 100;
  localparam int NB    = 4*BW;
  localparam int T_END = ST + (32 + 32*BW)*2*DIV;
  localparam logic [31:0] CMDADDR = 32'h0300_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vga_clk, vga_hs, vga_vs, vga_blk;
  logic [2:0] vga_r, vga_g;
  logic [1:0] vga_b;
  logic SDRAM_CLK, SDRAM_CKE, SDRAM_CSn, SDRAM_WEn, SDRAM_CASn, SDRAM_RASn;
  logic [12:0] SDRAM_A;
  logic [1:0]  SDRAM_BA, SDRAM_DQM;
  wire  [15:0] SDRAM_DQ;
  logic spi_clk, spi_data, spi_q, spi_wp, spi_hold, spi_cs;

  fpgc4_shell #(.BOOT_WORDS(BW), .SPI_DIV(DIV), .STARTUP_CYCLES(ST)) dut (
    .clk(clk), .reset(reset),
    .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_blk(vga_blk),
    .SDRAM_CLK(SDRAM_CLK), .SDRAM_CKE(SDRAM_CKE), .SDRAM_CSn(SDRAM_CSn),
    .SDRAM_WEn(SDRAM_WEn), .SDRAM_CASn(SDRAM_CASn), .SDRAM_RASn(SDRAM_RASn),
    .SDRAM_A(SDRAM_A), .SDRAM_BA(SDRAM_BA), .SDRAM_DQM(SDRAM_DQM), .SDRAM_DQ(SDRAM_DQ),
    .spi_clk(spi_clk), .spi_data(spi_data), .spi_q(spi_q),
    .spi_wp(spi_wp), .spi_hold(spi_hold), .spi_cs(spi_cs)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int t_q = 0;

  always @(posedge clk) t_q <= reset ? 0 : t_q + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t_q);
    end
  endtask

  // Flash: records the command/address stream, serves bytes after 32 clocks.
  logic [7:0]  flash [NB];
  int          fbit = 0;
  logic [31:0] fcmd = '0;
  logic        fq = 1'b0;
  assign spi_q = fq;

  initial begin
    flash[0] = 8'hDE; flash[1] = 8'hAD; flash[2] = 8'hBE; flash[3] = 8'hEF;
    for (int i = 4; i < NB; i++) flash[i] = 8'(i*29 + 7);
  end

  always @(posedge spi_clk or posedge spi_cs) begin
    if (spi_cs) fbit <= 0;
    else begin
      if (fbit < 32) fcmd <= {fcmd[30:0], spi_data};
      fbit <= fbit + 1;
    end
  end

  always @(negedge spi_clk)
    if (!spi_cs && fbit >= 32)
      fq <= flash[6'((fbit-32)/8)][3'(7 - ((fbit-32)%8))];

  int   cs_rise_t = -1, cs_fall_t = -1, pin_hits = 0, lines_meas = 0;
  int   nfall = 0, last_fall_t = 0, hs_low = 0, blk_cnt = 0;
  logic prev_cs = 1'b1, prev_hs = 1'b1;

  initial begin : cmp
    int t, u, te, k, h, v;
    logic vis;
    logic [7:0] exp_rgb, rgb;
    forever begin
      @(negedge clk);
      t   = t_q;
      rgb = {vga_r, vga_g, vga_b};
      chk("sdram_clk", SDRAM_CLK, 1'b1);
      chk("sdram_ctl", {SDRAM_CKE, SDRAM_CSn, SDRAM_RASn, SDRAM_CASn, SDRAM_WEn}, 5'b11111);
      chk("sdram_adr", {SDRAM_A, SDRAM_BA, SDRAM_DQM}, {13'd0, 2'd0, 2'b11});
      chk("spi_wp_hold", {spi_wp, spi_hold}, 2'b11);
      if (t == 0) begin
        chk("rst_spi", {spi_cs, spi_clk, spi_data}, 3'b100);
        chk("rst_vga", {vga_clk, vga_hs, vga_vs, vga_blk, rgb}, {4'b0110, 8'h00});
        nfall = 0; prev_hs = 1'b1;
      end else begin
        if (t < ST || t >= T_END) begin
          chk("spi_idle", {spi_cs, spi_clk}, 2'b10);
        end else begin
          u = t - ST;
          chk("spi_cs", spi_cs, 1'b0);
          chk("spi_clk", spi_clk, (u % (2*DIV)) >= DIV);
          if (u/(2*DIV) < 32) chk("spi_mosi", spi_data, CMDADDR[5'(31 - u/(2*DIV))]);
        end
        te = (t % 2 == 1) ? t : t - 1;
        k  = (te - 1) / 2;
        h  = k % 800;
        v  = (k / 800) % 525;
        vis = (h < 640) && (v < 480);
        exp_rgb = (vis && te > T_END) ? flash[6'((h/32) % NB)] : 8'h00;
        chk("vga_clk", vga_clk, t % 2);
        chk("vga_hs", vga_hs, !(h >= 656 && h <= 751));
        chk("vga_vs", vga_vs, !(v >= 490 && v <= 491));
        chk("vga_blk", vga_blk, vis);
        chk("vga_rgb", rgb, exp_rgb);
        if (t % 2 == 1) begin
          if (v == 0 && h == 5)   begin chk("pin_preboot", {vga_blk, rgb}, 9'h100); pin_hits++; end
          if (v == 2 && h == 0)   begin chk("pin_h0", rgb, 8'hDE); pin_hits++; end
          if (v == 2 && h == 32)  begin chk("pin_h32", {vga_r, vga_g, vga_b}, {3'b101, 3'b011, 2'b01}); pin_hits++; end
          if (v == 2 && h == 640) begin chk("pin_h640", {vga_blk, rgb}, 9'h000); pin_hits++; end
          if (prev_hs && !vga_hs) begin
            if (nfall > 0) begin
              chk("line_hs_low", hs_low, 96);
              chk("line_blk", blk_cnt, 640);
              chk("line_period", t - last_fall_t, 1600);
              lines_meas++;
            end
            nfall++; last_fall_t = t; hs_low = 0; blk_cnt = 0;
          end
          if (!vga_hs) hs_low++;
          if (vga_blk) blk_cnt++;
          prev_hs = vga_hs;
        end
        if (!prev_cs && spi_cs) cs_rise_t = t;
        if (prev_cs && !spi_cs) cs_fall_t = t;
      end
      prev_cs = spi_cs;
    end
  end

  initial begin
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (600) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6800) @(negedge clk);
    #1;
    chk("cs_fall_time", cs_fall_t, 100);
    chk("cs_rise_time", cs_rise_t, 2276);
    chk("flash_cmdaddr", fcmd, 32'h0300_0000);
    chk("pin_hits", pin_hits, 5);
    chk("lines_measured", lines_meas, 3);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
